imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream (e.g. from a UART receiver) and produces 32-bit word writes for the instruction memory's write port.
- Word addresses use the same byte-address convention the fetch path reads with: word index in address bits [ADDR_W+1:2], bits [1:0] = 0.
- Holds the core in reset until a complete program has been written, so fetch never reads unloaded words.

Parameters:
- ADDR_W, 8, word-index width; memory depth is 2^ADDR_W words (256 by default).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load of num_words words.
- num_words  in  ADDR_W+1  word count, sampled only on an accepted start; legal range is 1..2^ADDR_W.
- byte_in  in  8  program byte; the stream is little-endian per word.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer happens when valid && ready.
- we  out  1  write enable to the instruction memory; one-cycle pulse per word.
- waddr  out  32  byte address of the word being written.
- wdata  out  32  assembled word.
- busy  out  1  a load is in progress.
- done  out  1  last load completed successfully; sticky until the next accepted start.
- err  out  1  one-cycle pulse when a start is rejected.
- cpu_rst  out  1  core reset request; high while no valid program is loaded.

Behaviour:
- Reset values: state = IDLE; byte_ready = 0, we = 0, waddr = 0, wdata = 0, busy = 0, done = 0, err = 0, cpu_rst = 1.
- Reset clears all internal state. An asserted reset in the middle of a load aborts it: the partial word is discarded, no further writes are issued, and cpu_rst is forced to 1.
- States: IDLE, RECV, WRITE, DONE.
- IDLE / DONE, start with a legal num_words:
  - Latch num_words; clear the word index and byte count.
  - busy = 1, done = 0, cpu_rst = 1; go to RECV.
- IDLE / DONE, start with num_words = 0 or > 2^ADDR_W:
  - err = 1 for one cycle; state, done and cpu_rst are unchanged.
- start while in RECV or WRITE is ignored (no err pulse).
- RECV:
  - byte_ready = 1.
  - Each handshake stores byte_in into lane byte_cnt: lane 0 goes to wdata[7:0], lane 3 goes to wdata[31:24].
  - byte_cnt increments modulo 4. When the handshake fills lane 3, go to WRITE on the next edge.
  - byte_valid low means the loader waits indefinitely; there is no timeout.
- WRITE (exactly 1 cycle):
  - we = 1, waddr = {word_idx, 2'b00} zero-extended to 32 bits, wdata = the assembled word.
  - byte_ready = 0.
  - word_idx increments. If word_idx+1 == latched count, go to DONE; otherwise go to RECV.
- DONE: busy = 0, done = 1, cpu_rst = 0, byte_ready = 0.
- Latency: the write pulse occurs the cycle after the 4th byte handshake. Minimum is 5 cycles per word.
- Bytes presented while byte_ready = 0 are not consumed.
- Wrap / full: with num_words = 2^ADDR_W, the last write is to waddr = (2^ADDR_W − 1)·4 (0x3FC by default). The loader never issues an address beyond that.
- The word-index counter has ADDR_W+1 bits, so the comparison against a count of 2^ADDR_W is exact.
- If a new start is accepted from DONE, cpu_rst reasserts on the next cycle.

Test Plan:
- Reset, then start with num_words = 2; stream 13 05 10 00 93 05 20 00 with byte_valid held high -> we pulses with waddr 0x0 / wdata 0x00100513, then waddr 0x4 / wdata 0x00200593. done = 1, cpu_rst = 0, busy = 0 after the second write.
- Same load with byte_valid toggling 1-0-1-0 and multi-cycle gaps -> identical write sequence. byte_ready = 0 during each WRITE cycle; no bytes are lost or duplicated.
- start with num_words = 0, then 257 -> err pulses once each; state stays IDLE, cpu_rst = 1, no we.
- Assert rst after 6 bytes of a 3-word load -> only the waddr 0x0 write has occurred. Outputs return to reset values; a fresh 1-word load afterwards writes waddr 0x0.
- num_words = 256 with an incrementing byte pattern -> 256 writes, last waddr 0x3FC, no write to 0x400, then done = 1.
- Pulse start mid-load -> ignored. After done, a second start reasserts cpu_rst and reloads from waddr 0x0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: turns a little-endian program byte stream into 32-bit
// instruction-memory word writes. The core is held in reset (cpu_rst) until a
// complete program has been written.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [31:0]       waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  // Largest legal word count: the whole memory.
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] word_idx;
  logic [1:0]      byte_cnt;
  logic [23:0]     lanes;
  logic [ADDR_W:0] idx_next;
  logic            take;

  // A word count is usable only if it is non-zero and fits in the memory.
  function automatic logic count_ok(input logic [ADDR_W:0] n);
    return (n != '0) && (n <= MAX_WORDS);
  endfunction

  // word_idx is one bit wider than an address so a full-memory count compares exactly.
  assign idx_next = word_idx + 1'b1;
  assign take     = (state == RECV) && byte_ready && byte_valid;

  // Load sequencer: all outputs are registered and updated with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      lanes      <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst    <= 1'b1;
    end else begin
      we  <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (count_ok(num_words)) begin
              count      <= num_words;
              word_idx   <= '0;
              byte_cnt   <= '0;
              busy       <= 1'b1;
              done       <= 1'b0;
              cpu_rst    <= 1'b1;
              byte_ready <= 1'b1;
              state      <= RECV;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RECV: begin
          if (take) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: lanes[7:0]   <= byte_in;
              2'd1: lanes[15:8]  <= byte_in;
              2'd2: lanes[23:16] <= byte_in;
              default: begin
                // Last lane completes the word: present it on the write port next cycle.
                wdata      <= {byte_in, lanes};
                waddr      <= 32'({word_idx[ADDR_W-1:0], 2'b00});
                we         <= 1'b1;
                byte_ready <= 1'b0;
                state      <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          word_idx <= idx_next;
          if (idx_next == count) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
            state   <= DONE;
          end else begin
            byte_ready <= 1'b1;
            state      <= RECV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with hand-computed expected writes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  num_words;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Record every write and the handshake state seen with it.
  always @(negedge clk) begin
    if (we) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
      chk("ready_low_in_write", 32'(byte_ready), 32'd0);
      chk("waddr_in_range", 32'(waddr <= 32'h3FC), 32'd1);
    end
    if (err) err_cnt++;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_waddr"}, waddr, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    wa_q.delete();
    wd_q.delete();
    err_cnt = 0;
  endtask

  task automatic do_start(input logic [8:0] n);
    @(negedge clk);
    start = 1'b1;
    num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after `gap` idle cycles and hold it until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in = b;
    n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("byte_accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_timeout"}, 32'(n < 50), 32'd1);
  endtask

  task automatic check_prog2(input string tag);
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      chk({tag, "_a0"}, wa_q[0], 32'h0);
      chk({tag, "_d0"}, wd_q[0], 32'h00100513);
      chk({tag, "_a1"}, wa_q[1], 32'h4);
      chk({tag, "_d1"}, wd_q[1], 32'h00200593);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic [7:0] prog [8];
  logic [31:0] exp_w;

  initial begin
    prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'h10; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h05; prog[6] = 8'h20; prog[7] = 8'h00;
    rst = 1'b1;
    start = 1'b0;
    num_words = '0;
    byte_in = '0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    do_reset();

    // Two-word program streamed back to back.
    do_start(9'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cpu_rst", 32'(cpu_rst), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
    wait_done("t1");
    check_prog2("t1");

    // Reload from DONE with gapped bytes and a stray start mid-load.
    wa_q.delete();
    wd_q.delete();
    do_start(9'd2);
    chk("t2_cpu_rst_reassert", 32'(cpu_rst), 32'd1);
    chk("t2_done_clear", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], i % 3 + 1);
      if (i == 2) do_start(9'd1);
    end
    wait_done("t2");
    check_prog2("t2");
    chk("t2_no_err", 32'(err_cnt), 32'd0);

    // Illegal word counts are rejected from IDLE.
    do_reset();
    do_start(9'd0);
    chk("t3_err0", 32'(err), 32'd1);
    chk("t3_busy0", 32'(busy), 32'd0);
    do_start(9'd257);
    chk("t3_err257", 32'(err), 32'd1);
    chk("t3_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t3_ready", 32'(byte_ready), 32'd0);
    @(negedge clk);
    chk("t3_err_pulses", 32'(err_cnt), 32'd2);
    chk("t3_no_writes", 32'(wa_q.size()), 32'd0);

    // Reset in the middle of a three-word load.
    do_start(9'd3);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 0);
    chk("t4_partial_writes", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) chk("t4_a0", wa_q[0], 32'h0);
    do_reset();
    repeat (3) @(negedge clk);
    chk("t4_no_writes_after_rst", 32'(wa_q.size()), 32'd0);
    do_start(9'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    wait_done("t4");
    chk("t4_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      chk("t4_fresh_a", wa_q[0], 32'h0);
      chk("t4_fresh_d", wd_q[0], 32'hDDCCBBAA);
    end
    chk("t4_cpu_rst", 32'(cpu_rst), 32'd0);

    // Full-memory load with an incrementing byte pattern.
    do_reset();
    do_start(9'd256);
    for (int i = 0; i < 1024; i++) send_byte(8'(i), 0);
    wait_done("t5");
    repeat (3) @(negedge clk);
    chk("t5_nwrites", 32'(wa_q.size()), 32'd256);
    if (wa_q.size() == 256) begin
      for (int k = 0; k < 256; k++) begin
        exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        chk($sformatf("t5_a%0d", k), wa_q[k], 32'(k*4));
        chk($sformatf("t5_d%0d", k), wd_q[k], exp_w);
      end
      chk("t5_last_addr", wa_q[255], 32'h3FC);
    end
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_cpu_rst", 32'(cpu_rst), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
